// File: rtl/unified_mem_responder.sv
// Single-port 16-bit word memory responder with fixed request-to-response latency.
// Optional macro UMEM_ALIGN_CHECK_EN rejects odd byte addresses with rsp_err.
module unified_mem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rest,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [15:0]           wdata_q, wdata_d;
    logic                  odd_q, odd_d;
    logic [15:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [15:0]           mem [DEPTH];

    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  req_odd;
    logic                  access;
    logic                  acc_write;
    logic                  acc_odd;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic [15:0]           acc_wdata;
    logic                  mem_we;
    logic                  unused_addr;

    assign req_idx     = req_addr[DEPTH_LOG2:1];
    assign unused_addr = ^req_addr;

`ifdef UMEM_ALIGN_CHECK_EN
    assign req_odd = req_addr[0];
`else
    assign req_odd = 1'b0;
`endif

    // The array is touched only on the edge that enters RESP; with LATENCY==1 that
    // is the accepting edge itself, so the live request fields are used directly.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        write_d   = write_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        odd_d     = odd_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        access    = 1'b0;
        acc_write = write_q;
        acc_odd   = odd_q;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    idx_d   = req_idx;
                    wdata_d = req_wdata;
                    odd_d   = req_odd;
                    cnt_d   = CNT_LOAD;
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                    end else begin
                        state_d   = RESP;
                        access    = 1'b1;
                        acc_write = req_write;
                        acc_odd   = req_odd;
                        acc_idx   = req_idx;
                        acc_wdata = req_wdata;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    access  = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = 16'h0000;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (access) begin
            err_d   = acc_odd;
            rdata_d = (acc_write || acc_odd) ? 16'h0000 : mem[acc_idx];
        end
    end

    // Reset aborts any pending write even if it coincides with the access edge.
    assign mem_we = access && acc_write && !acc_odd && !rest;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 16'h0000;
            odd_q   <= 1'b0;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            odd_q   <= odd_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == IDLE) && !rest;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/unified_mem_responder.md
UNIFIED_MEM_RESPONDER -- requirements
Module: unified_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of the number of 16-bit words in the array.
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request accept to rsp_valid (legal 1..15).
REQ-003 SHALL have one clock and an asynchronous, active-high reset; clock port clk, reset port rest.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rest  input  1  asynchronous active-high reset.
REQ-006 req_valid  input  1  initiator (fetch or data stage) presents a request.
REQ-007 req_ready  output  1  responder accepts a request this cycle.
REQ-008 req_write  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  16  byte address; word index = req_addr[DEPTH_LOG2:1].
REQ-010 req_wdata  input  16  write data.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  initiator consumes the response.
REQ-013 rsp_rdata  output  16  read data (0 for writes and errors).
REQ-014 rsp_err  output  1  access rejected (misaligned).
REQ-015 busy  output  1  responder not in IDLE; drives pipeline freeze logic.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 IDLE: req_ready=1; on req_valid SHALL capture write/addr/wdata, load wait counter with LATENCY-1, go to WAIT if LATENCY>1 else RESP.
REQ-018 WAIT: SHALL decrement the counter each cycle; at counter==1 SHALL perform the array access and go to RESP next cycle.
REQ-019 Array access (reads registered into rsp_rdata, writes committed) SHALL occur on the edge entering RESP; rsp_valid first asserts exactly LATENCY cycles after the accepting edge.
REQ-020 RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready=1; on rsp_ready SHALL return to IDLE next cycle.
REQ-021 req_ready SHALL be 0 in WAIT and RESP; req_valid there SHALL be ignored (initiator holds it).
REQ-022 Minimum request spacing SHALL be LATENCY+1 cycles (RESP->IDLE->accept).
REQ-023 Address bits above DEPTH_LOG2 SHALL be ignored; accesses alias (wrap) modulo 2^DEPTH_LOG2 words.
REQ-024 Write response SHALL return rsp_rdata=0, rsp_err=0; a read of a word written by an earlier completed write SHALL return the new value.
REQ-025 busy SHALL equal (state != IDLE).
REQ-026 rsp_ready while rsp_valid=0 SHALL have no effect.

Reset
REQ-027 rest=1 SHALL immediately force IDLE, counter 0, req_ready=1 (after release), rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
REQ-028 Reset in WAIT or RESP SHALL drop the pending request with no write performed; array contents SHALL NOT be cleared.

Configuration
REQ-029 Macro UMEM_ALIGN_CHECK_EN defined: accepted request with req_addr[0]=1 SHALL complete with normal latency, rsp_err=1, rsp_rdata=0, write suppressed.
REQ-030 Macro UMEM_ALIGN_CHECK_EN undefined: req_addr[0] SHALL be ignored, rsp_err tied 0.

Verification
REQ-031 Write 0x1234 to 0x0010, then read 0x0010, LATENCY=2 -> read rsp_valid 2 cycles after accept, rsp_rdata=0x1234, rsp_err=0.
REQ-032 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0, busy=1 throughout; new req_valid not accepted.
REQ-033 DEPTH_LOG2=8: write 0xBEEF to 0x0002, read 0x0202 -> rsp_rdata=0xBEEF (aliasing).
REQ-034 rest pulsed one cycle into WAIT of a write 0xAAAA to 0x0004 -> busy=0 next, later read of 0x0004 returns prior value, not 0xAAAA.
REQ-035 With UMEM_ALIGN_CHECK_EN: write 0x5555 to 0x0007 -> rsp_err=1, read of 0x0006 unchanged; without macro -> rsp_err=0, 0x0006 reads 0x5555.
REQ-036 LATENCY=1, rsp_ready tied 1, req_valid tied 1 -> accept every 2nd cycle, rsp_valid 1 cycle after each accept.
